// File: rtl/contador_pkg.sv
// Shared definitions for the parameterised counter.
// Operating-mode encodings used on MODO.
package contador_pkg;

  localparam logic [2:0] M_UP        = 3'b000;
  localparam logic [2:0] M_DOWN      = 3'b001;
  localparam logic [2:0] M_UP_STEP   = 3'b010;
  localparam logic [2:0] M_LOAD      = 3'b011;
  localparam logic [2:0] M_DOWN_STEP = 3'b100;

endpackage

// File: rtl/contador_paridad.sv
// Parity generator for the counter register.
// Even parity is XOR of all bits; odd parity is its complement.
module contador_paridad #(
  parameter int WIDTH   = 16,
  parameter int PAR_ODD = 0
) (
  input  logic [WIDTH-1:0] q,
  output logic             par
);

  always_comb begin
    par = ^q;
    if (PAR_ODD != 0)
      par = ~^q;
  end

endmodule

// File: rtl/contador_param.sv
// Up/down/step/load counter with registered carry flag.
// Carry and borrow both come from the extra top bit.
module contador_param
  import contador_pkg::*;
#(
  parameter int          WIDTH   = 16,
  parameter int unsigned STEP    = 3,
  parameter int          PAR_ODD = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENB,
  input  logic             CI,
  input  logic [2:0]       MODO,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             Paridad
);

  localparam logic [WIDTH:0] ONE   = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] STEPW = (WIDTH+1)'(STEP);

  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q_nxt;
  logic             rco_nxt;

  always_comb begin
    acc     = {1'b0, Q};
    q_nxt   = Q;
    rco_nxt = 1'b0;
    if (ENB) begin
      unique case (MODO)
        M_UP:        acc = {1'b0, Q} + ONE;
        M_DOWN:      acc = {1'b0, Q} - ONE;
        M_UP_STEP:   acc = {1'b0, Q} + STEPW;
        M_DOWN_STEP: acc = {1'b0, Q} - STEPW;
        default:     acc = {1'b0, Q};
      endcase
      unique case (MODO)
        M_UP, M_DOWN, M_UP_STEP, M_DOWN_STEP: begin
          if (CI) begin
            q_nxt   = acc[WIDTH-1:0];
            rco_nxt = acc[WIDTH];
          end
        end
        M_LOAD:  q_nxt = D;
        default: q_nxt = Q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      Q   <= '0;
      RCO <= 1'b0;
    end else begin
      Q   <= q_nxt;
      RCO <= rco_nxt;
    end
  end

  contador_paridad #(
    .WIDTH   (WIDTH),
    .PAR_ODD (PAR_ODD)
  ) u_par (
    .q   (Q),
    .par (Paridad)
  );

endmodule

// File: doc/contador_param.md
CONTADOR_PARAM -- requirements
Module: contador_param

Interface
REQ-001 SHALL have parameter WIDTH, default 16: counter width in bits, legal range 4..32.
REQ-002 SHALL have parameter STEP, default 3: stride for the step modes, legal range 1..2**WIDTH-1.
REQ-003 SHALL have parameter PAR_ODD, default 0: 0 selects even parity (XOR of Q), 1 selects odd parity (XNOR of Q).
REQ-004 SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port RESET, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port ENB, input, 1 bit: global enable.
REQ-007 SHALL have port CI, input, 1 bit: cascade carry-in; gates the count modes only.
REQ-008 SHALL have port MODO, input, 3 bits: operating mode.
REQ-009 SHALL have port D, input, WIDTH bits: parallel-load data.
REQ-010 SHALL have port Q, output, WIDTH bits: registered count.
REQ-011 SHALL have port RCO, output, 1 bit: registered ripple-carry/borrow flag.
REQ-012 SHALL have port Paridad, output, 1 bit: parity of Q, combinational from the Q register.

Function
REQ-013 SHALL decode MODO as follows: 000 count up by 1; 001 count down by 1; 010 count up by STEP; 011 parallel load; 100 count down by STEP; 101, 110 and 111 hold.
REQ-014 SHALL perform all arithmetic as unsigned modulo 2**WIDTH, with carry/borrow taken from bit WIDTH of a WIDTH+1-bit intermediate.
REQ-015 SHALL update Q on the rising edge after the inputs are sampled (latency 1 cycle), and only when ENB=1.
REQ-016 SHALL, in the count modes (000, 001, 010, 100), update Q only when ENB=1 and CI=1; otherwise Q holds.
REQ-017 SHALL, in load mode (011) with ENB=1, load Q<=D regardless of CI.
REQ-018 SHALL set RCO=1 for exactly the cycle following an update whose add overflowed or whose subtract borrowed: up 0xFFFF->0x0000, down 0x0000->0xFFFF, and step wraps such as 0xFFFE+3->0x0001.
REQ-019 SHALL drive RCO=0 after any load, hold, reserved-mode or disabled cycle, and after any count cycle without a wrap.
REQ-020 SHALL NOT assert RCO on two consecutive cycles unless a wrap occurs on each of those cycles (possible only when STEP is large).
REQ-021 SHALL drive Paridad as ^Q when PAR_ODD=0 and as ~^Q when PAR_ODD=1, updating in the same cycle that Q changes.
REQ-022 SHALL treat MODO or D changing on any cycle as taking effect at the next edge, with no internal pipelining or mode latching.

Reset
REQ-023 SHALL, when RESET=1 at a rising edge, set Q=0 and RCO=0, overriding ENB, CI, MODO and D; Paridad then equals PAR_ODD.
REQ-024 SHALL, when reset is asserted mid-count or mid-load, discard the pending operation entirely.
REQ-025 SHALL resume normal operation on the first edge after RESET returns to 0.

Structure
REQ-026 SHALL place the MODO encodings (M_UP, M_DOWN, M_UP_STEP, M_LOAD, M_DOWN_STEP) in the shared package contador_pkg.
REQ-027 SHALL instantiate the sub-module contador_paridad (parameter WIDTH, PAR_ODD) to generate Paridad.
REQ-028 SHALL place the next-state/carry logic in the top level.

Verification (WIDTH=16, STEP=3, PAR_ODD=0)
REQ-029 SHALL cover reset then count: RESET 2 cycles, then ENB=1, CI=1, MODO=000 for 20 cycles -> Q=0x0014, RCO never 1.
REQ-030 SHALL cover load and up-wrap: load D=0xFFFE, then MODO=000 -> Q=0xFFFF (RCO=0), then Q=0x0000 (RCO=1), then Q=0x0001 (RCO=0).
REQ-031 SHALL cover down count: load D=15, then MODO=001 for 16 cycles -> Q steps 14..0, then 0xFFFF with RCO=1 in that cycle.
REQ-032 SHALL cover the step modes: load 0xFFFD, MODO=010 -> Q=0x0000 with RCO=1; load 2, MODO=100 -> Q=0xFFFF with RCO=1.
REQ-033 SHALL cover gating and reserved modes: mid-count CI=0 or ENB=0 or MODO=110 -> Q frozen and RCO=0; CI=0 with MODO=011 and D=0x0009 -> Q=0x0009.
REQ-034 SHALL cover parity and mid-operation reset: Q=0x0007 -> Paridad=1, Q=0x0003 -> Paridad=0; RESET=1 during MODO=011 with D=0x1234 -> Q=0 next edge.
